// File: rtl/ex_stage.sv
// GeMIPS execute stage: combinational single-cycle ALU, load/store address
// generation and an iterative shift-add multiplier that stalls the front end.
module ex_stage #(
  parameter int unsigned MUL_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [3:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] link_addr_i,
  input  logic        flush_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] store_data_o,
  output logic [7:0]  aluop_o,
  output logic        stall_req_o,
  output logic        busy_o
);

  localparam int unsigned K  = 32 / MUL_STEP;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [7:0] ALU_OP_NOP = 8'h00;
  localparam logic [7:0] ALU_OP_ADD = 8'h20;
  localparam logic [7:0] ALU_OP_AND = 8'h24;
  localparam logic [7:0] ALU_OP_OR  = 8'h25;
  localparam logic [7:0] ALU_OP_XOR = 8'h26;
  localparam logic [7:0] ALU_OP_SRL = 8'h02;
  localparam logic [7:0] ALU_OP_SLL = 8'h7C;
  localparam logic [7:0] ALU_OP_LUI = 8'h5C;
  localparam logic [7:0] ALU_OP_JAR = 8'h50;
  localparam logic [7:0] ALU_OP_MUL = 8'hA9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     acc, mcand, mplier, pp, alu_res;
  logic [CW-1:0]   cnt;
  logic            stall;
  logic            is_mul;

  // alusel and the upper instruction bits are not needed by this stage
  logic unused_bits;
  assign unused_bits = ^{alusel_i, inst_i[31:16]};

  assign is_mul = (aluop_i == ALU_OP_MUL);

  // MUL_STEP low multiplier bits retired as a sum of shifted multiplicands
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (is_mul) begin
        stall     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == CW'(K - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt = IDLE;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == BUSY) begin
        acc    <= '0;
        mcand  <= reg1_i;
        mplier <= reg2_i;
        cnt    <= '0;
      end else if (state == BUSY && !flush_i) begin
        acc    <= acc + pp;
        mcand  <= mcand << MUL_STEP;
        mplier <= mplier >> MUL_STEP;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    alu_res = '0;
    case (aluop_i)
      ALU_OP_ADD: alu_res = reg1_i + reg2_i;
      ALU_OP_AND: alu_res = reg1_i & reg2_i;
      ALU_OP_OR:  alu_res = reg1_i | reg2_i;
      ALU_OP_XOR: alu_res = reg1_i ^ reg2_i;
      ALU_OP_SLL: alu_res = reg1_i << reg2_i[4:0];
      ALU_OP_SRL: alu_res = reg1_i >> reg2_i[4:0];
      ALU_OP_LUI: alu_res = {reg2_i[15:0], 16'h0000};
      ALU_OP_JAR: alu_res = link_addr_i;
      ALU_OP_NOP: alu_res = '0;
      default:    alu_res = '0;
    endcase
  end

  // Outputs read as zero while reset is held, independent of the inputs
  always_comb begin
    wdata_o      = (state == DONE) ? acc : alu_res;
    waddr_o      = waddr_i;
    we_o         = we_i && !stall && !flush_i;
    mem_addr_o   = reg1_i + {{16{inst_i[15]}}, inst_i[15:0]};
    store_data_o = reg2_i;
    aluop_o      = aluop_i;
    stall_req_o  = stall;
    busy_o       = (state != IDLE);
    if (rst) begin
      wdata_o      = '0;
      waddr_o      = '0;
      we_o         = 1'b0;
      mem_addr_o   = '0;
      store_data_o = '0;
      aluop_o      = '0;
      stall_req_o  = 1'b0;
      busy_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: cycle-level reference model plus
// directed vectors with hand-computed results.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SLL = 8'h7C;
  localparam logic [7:0] OP_LUI = 8'h5C;
  localparam logic [7:0] OP_JAR = 8'h50;
  localparam logic [7:0] OP_MUL = 8'hA9;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam int K = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop, aluop2;
  logic [3:0]  alusel;
  logic [31:0] reg1, reg2, inst, link;
  logic [4:0]  waddr;
  logic        we, flush, flush2;

  logic [31:0] wdata, mem_addr, store_data;
  logic [4:0]  waddr_q;
  logic        we_q, stall, busy;
  logic [7:0]  aluop_q;

  logic [31:0] wdata2, mem_addr2, store_data2;
  logic [4:0]  waddr_q2;
  logic        we_q2, stall2, busy2;
  logic [7:0]  aluop_q2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .waddr_i(waddr), .we_i(we),
    .inst_i(inst), .link_addr_i(link), .flush_i(flush),
    .wdata_o(wdata), .waddr_o(waddr_q), .we_o(we_q), .mem_addr_o(mem_addr),
    .store_data_o(store_data), .aluop_o(aluop_q), .stall_req_o(stall),
    .busy_o(busy)
  );

  ex_stage #(.MUL_STEP(2)) dut2 (
    .clk(clk), .rst(rst), .aluop_i(aluop2), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .waddr_i(waddr), .we_i(we),
    .inst_i(inst), .link_addr_i(link), .flush_i(flush2),
    .wdata_o(wdata2), .waddr_o(waddr_q2), .we_o(we_q2), .mem_addr_o(mem_addr2),
    .store_data_o(store_data2), .aluop_o(aluop_q2), .stall_req_o(stall2),
    .busy_o(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] l);
    case (op)
      OP_ADD:  return a + b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_LUI:  return {b[15:0], 16'h0000};
      OP_JAR:  return l;
      default: return 32'h0;
    endcase
  endfunction

  // Reference: m counts edges since a MUL was accepted (0 = no multiply pending)
  int          m = 0;
  logic [31:0] prod = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) m <= 0;
    else if (m == 0) begin
      if (aluop == OP_MUL && !flush) begin
        m    <= 1;
        prod <= reg1 * reg2;
      end
    end else if (flush || m == K + 1) m <= 0;
    else m <= m + 1;
  end

  always @(negedge clk) begin : cmp
    logic [31:0] e_wd;
    logic        e_we, e_st, e_bz, chk_wd;
    e_wd = '0; e_we = 1'b0; e_st = 1'b0; e_bz = 1'b0; chk_wd = 1'b1;
    if (rst) begin
      chk_wd = 1'b1;
    end else if (m == 0) begin
      if (aluop == OP_MUL && !flush) begin
        e_st = 1'b1; chk_wd = 1'b0;
      end else begin
        e_we = we && !flush;
        e_wd = alu_ref(aluop, reg1, reg2, link);
      end
    end else if (m <= K) begin
      e_bz = 1'b1; e_st = !flush; chk_wd = 1'b0;
    end else begin
      e_bz = 1'b1; e_we = we && !flush; e_wd = prod;
    end
    if (chk_wd) check("wdata", wdata, e_wd);
    check("we", {31'b0, we_q}, {31'b0, e_we});
    check("stall", {31'b0, stall}, {31'b0, e_st});
    check("busy", {31'b0, busy}, {31'b0, e_bz});
    check("waddr", {27'b0, waddr_q}, rst ? 32'h0 : {27'b0, waddr});
    check("mem_addr", mem_addr, rst ? 32'h0 : reg1 + {{16{inst[15]}}, inst[15:0]});
    check("store_data", store_data, rst ? 32'h0 : reg2);
    check("aluop", {24'b0, aluop_q}, rst ? 32'h0 : {24'b0, aluop});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic w);
    aluop = op; reg1 = a; reg2 = b; waddr = wa; we = w;
  endtask

  // Issue a MUL on dut (sel=0) or dut2 (sel=1), count stall cycles, check the DONE cycle
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_res, input logic sel);
    int n;
    set_in(sel ? OP_NOP : OP_MUL, a, b, 5'd9, 1'b1);
    aluop2 = sel ? OP_MUL : OP_NOP;
    n = 0;
    @(negedge clk);
    while ((sel ? stall2 : stall) === 1'b1 && n < 60) begin
      if ((sel ? we_q2 : we_q) !== 1'b0) check("mul_we_during_stall", 32'h1, 32'h0);
      n++;
      @(negedge clk);
    end
    check(sel ? "mul2_stall_cycles" : "mul_stall_cycles", n, exp_stall);
    check(sel ? "mul2_result" : "mul_result", sel ? wdata2 : wdata, exp_res);
    check(sel ? "mul2_done_we" : "mul_done_we", {31'b0, sel ? we_q2 : we_q}, 32'h1);
    step();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "add_wrap"};
    vecs[1] = '{OP_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "sll31"};
    vecs[2] = '{OP_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, "srl4"};
    vecs[3] = '{OP_LUI, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, "lui"};
    vecs[4] = '{OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, "and"};
    vecs[5] = '{OP_OR,  32'hF000_0001, 32'h000F_0010, 32'hF00F_0011, "or"};
    vecs[6] = '{OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, "xor"};
    vecs[7] = '{OP_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, "nop"};

    rst = 1'b1; aluop = OP_NOP; aluop2 = OP_NOP; alusel = 4'h0;
    reg1 = 32'h1111_2222; reg2 = 32'h3333_4444; inst = 32'h0000_0010;
    link = 32'h0; waddr = 5'd7; we = 1'b1; flush = 1'b0; flush2 = 1'b0;
    #1;
    check("reset_wdata", wdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_store_data", store_data, 32'h0);
    step(); step();
    rst = 1'b0;

    // reset during the third BUSY iteration
    set_in(OP_MUL, 32'd3, 32'd4, 5'd4, 1'b1);
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("rst_busy_stall", {31'b0, stall}, 32'h0);
    check("rst_busy_busy", {31'b0, busy}, 32'h0);
    check("rst_busy_we", {31'b0, we_q}, 32'h0);
    step();
    rst = 1'b0;
    run_mul(32'd5, 32'd7, K + 1, 32'd35, 1'b0);

    // single-cycle ops
    foreach (vecs[i]) begin
      set_in(vecs[i].op, vecs[i].a, vecs[i].b, 5'd3, 1'b1);
      #1;
      check(vecs[i].name, wdata, vecs[i].exp);
      if (i == 0) begin
        check("add_waddr", {27'b0, waddr_q}, 32'd3);
        check("add_we", {31'b0, we_q}, 32'h1);
        check("add_stall", {31'b0, stall}, 32'h0);
      end
      step();
    end

    // multiply, then back-to-back multiply
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, K + 1, 32'h0000_0001, 1'b0);
    run_mul(32'd3, 32'hFFFF_FFFE, K + 1, 32'hFFFF_FFFA, 1'b0);

    // load / store address, jump-and-link
    set_in(OP_LW, 32'h8000_0010, 32'h0, 5'd2, 1'b1);
    inst = 32'h8C22_FFF0;
    #1;
    check("load_addr", mem_addr, 32'h8000_0000);
    check("load_wdata", wdata, 32'h0);
    step();
    set_in(OP_SW, 32'h0000_1000, 32'hCAFE_F00D, 5'd0, 1'b0);
    inst = 32'hAC22_0008;
    #1;
    check("store_addr", mem_addr, 32'h0000_1008);
    check("store_data", store_data, 32'hCAFE_F00D);
    step();
    set_in(OP_JAR, 32'h0, 32'h0, 5'd31, 1'b1);
    link = 32'hBFC0_0108;
    #1;
    check("jar_wdata", wdata, 32'hBFC0_0108);
    check("jar_waddr", {27'b0, waddr_q}, 32'd31);
    step();

    // flush during the fifth BUSY iteration
    set_in(OP_MUL, 32'd123, 32'd456, 5'd6, 1'b1);
    repeat (5) step();
    check("pre_flush_busy", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall}, 32'h0);
    check("flush_we", {31'b0, we_q}, 32'h0);
    step();
    flush = 1'b0;
    aluop = OP_NOP;
    #1;
    check("post_flush_busy", {31'b0, busy}, 32'h0);
    check("post_flush_wdata", wdata, 32'h0);
    step();

    // narrower multiplier step
    run_mul(32'h1234_5678, 32'd9, 17, 32'hA3D7_0A38, 1'b1);
    aluop2 = OP_NOP;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the GeMIPS five-stage pipeline. It consumes the ID/EX-registered outputs of the decode stage (aluop, operands, write target, instruction word, link address). It produces the EX write-back triple, which also drives the decode stage's ex_* forwarding inputs, plus the load/store effective address. Single-cycle ops are combinational. MUL runs on an iterative shift-add multiplier that stalls the front of the pipeline until the product is ready.

Parameters:
MUL_STEP, 4, multiplier bits retired per iteration; must divide 32; K = 32/MUL_STEP iterations (default 8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
aluop_i  in  8  sub-operation, shared ALU_OP_* encodings
alusel_i  in  4  operation class, passed through
reg1_i  in  32  source operand 1
reg2_i  in  32  source operand 2 (register, immediate or sa)
waddr_i  in  5  destination register
we_i  in  1  destination write enable
inst_i  in  32  instruction word, used for the load/store offset
link_addr_i  in  32  return address for JAL
flush_i  in  1  abort the in-flight instruction (exception/redirect)
wdata_o  out  32  write-back data; also drives decode ex_wdata_i
waddr_o  out  5  write-back address; also drives decode ex_waddr_i
we_o  out  1  write-back enable; also drives decode ex_we_i
mem_addr_o  out  32  load/store effective address
store_data_o  out  32  equals reg2_i
aluop_o  out  8  equals aluop_i, for the memory stage
stall_req_o  out  1  request that the pipeline controller freeze PC, IF/ID and ID/EX
busy_o  out  1  multiplier state not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, mcand=0, mplier=0, cnt=0. Outputs settle combinationally to wdata_o=0, waddr_o=0, we_o=0, mem_addr_o=0, store_data_o=0, aluop_o=0, stall_req_o=0, busy_o=0. Any in-flight multiply is lost.
- Single-cycle results are combinational from the inputs, with zero added latency:
  - ADD: reg1+reg2 mod 2^32.
  - AND, OR, XOR: bitwise.
  - SLL: reg1 << reg2[4:0].
  - SRL: logical reg1 >> reg2[4:0].
  - LUI: {reg2[15:0], 16'h0}.
  - JAR: link_addr_i.
  - NOP and unknown ops: 0.
- Pass-through: waddr_o=waddr_i; we_o=we_i, except where forced low below.
- mem_addr_o = reg1_i + sign-extended inst_i[15:0], always computed. For loads wdata_o=0, and the memory stage supplies the data.
- MUL FSM, states IDLE -> BUSY -> DONE -> IDLE:
  - IDLE with aluop_i=MUL and flush_i=0: stall_req_o=1 combinationally, we_o=0. On the clock edge: load mcand=reg1, mplier=reg2, acc=0, cnt=0, go to BUSY.
  - BUSY: stall_req_o=1, we_o=0. Each cycle: acc += mcand*mplier[MUL_STEP-1:0], truncated to 32 bits; mcand <<= MUL_STEP; mplier >>= MUL_STEP; cnt++. After the K-th iteration (cnt reaches K-1 at the edge), go to DONE.
  - DONE: stall_req_o=0, wdata_o=acc, we_o=we_i. Next edge goes to IDLE unconditionally, even if the next instruction is also MUL; that MUL starts from IDLE.
  - Result is the low 32 bits of the product, identical for signed and unsigned operands.
  - Total stall is 1+K cycles (9 at default). The result is visible in the (K+2)th cycle after issue.
- The ID/EX register holds inputs stable while stall_req_o=1. The block does not re-latch operands in BUSY.
- flush_i=1 in any state: next state IDLE, we_o forced to 0 that cycle, stall_req_o=0.
- Overflow is not trapped for any op; wrap is modulo 2^32.

Test Plan:
- Reset mid-BUSY: assert rst in iteration 3 -> same cycle stall_req_o=0, busy_o=0, we_o=0. After release, a fresh MUL 5*7 completes with 35.
- ADD 0xFFFF_FFFF + 2, waddr 3, we 1 -> same cycle wdata_o=1, waddr_o=3, we_o=1, stall_req_o=0.
- SLL reg1=1, reg2=31 -> wdata_o=0x8000_0000. SRL reg1=0x8000_0000, reg2=4 -> 0x0800_0000. LUI reg2=0x1234 -> 0x1234_0000.
- MUL 0xFFFF_FFFF*0xFFFF_FFFF (default MUL_STEP) -> stall_req_o high for exactly 9 cycles, we_o low throughout. DONE cycle gives wdata_o=1, we_o=1. Back-to-back MUL 3*(-2) then yields 0xFFFF_FFFA after another 9-cycle stall.
- Load with reg1=0x8000_0010, inst[15:0]=0xFFF0 -> mem_addr_o=0x8000_0000. JAR with link_addr_i=0xBFC0_0108, waddr 31 -> wdata_o=0xBFC0_0108.
- flush_i pulse at BUSY iteration 5 -> next cycle IDLE, we_o=0, no write of a partial product. Then a MUL with MUL_STEP=2 takes a 17-cycle stall.
